pipe_sel_reg: RTL and testbench
===============================

Name: pipe_sel_reg

Overview:
- Parametrised N-way operand select with a registered output stage and valid/ready handshake.
- Successor to the combinational 2:1/4:1 selects; used for forwarding/operand selection at pipeline-register boundaries (e.g. the ID/EX operand latch).
- Adds stall hold, flush, defined out-of-range select handling and error reporting, none of which the combinational selects provide.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 2).
- SEL_W, $clog2(N), select width; minimum 1.
- DEFAULT_VAL, 0, value registered when the select is out of range.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  channel select.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept a beat (combinational).
- flush  input  1  kill the registered beat and block acceptance this cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream consumes the beat.
- err_clr  input  1  clear sel_err and err_count.
- sel_err  output  1  sticky flag: an out-of-range select was accepted.
- err_count  output  CNT_W  saturating count of accepted out-of-range selects.

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, sel_err=0, err_count=0. Reset takes effect immediately, including mid-transfer; the in-flight beat is lost.
- Ready/accept:
  - in_ready = !flush && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
  - Single register stage; data latency is exactly 1 cycle from accept to out_valid.
- On accept:
  - out_data <= in_data channel in_sel if in_sel < N, else DEFAULT_VAL.
  - out_valid <= 1.
- No accept, out_valid && out_ready: out_valid <= 0; out_data holds its last value.
- No accept, out_valid && !out_ready (stall): out_data and out_valid hold. Registered data never changes while out_valid=1 and out_ready=0.
- Full throughput: out_valid && out_ready && in_valid accepts a new beat in the same cycle, giving back-to-back beats with no bubble.
- flush: has priority over everything. Next cycle out_valid=0 regardless of out_ready. in_ready=0 in the flush cycle, so no beat is accepted or dropped silently. out_data is not cleared.
- in_valid asserted with in_ready low: upstream must hold in_data/in_sel stable (standard valid/ready rule). The stage does not sample them.
- Out-of-range select (in_sel >= N, possible only when N is not a power of 2), on accept only:
  - sel_err <= 1.
  - err_count <= err_count + 1, saturating at 2^CNT_W-1.
- Non-accepted out-of-range selects have no effect.
- err_clr:
  - Alone: sel_err <= 0 and err_count <= 0 next cycle.
  - Same cycle as an accepted out-of-range select: result is sel_err=1, err_count=1 (clear, then count).
- Width rules: all channels are the same WIDTH. No sign or zero extension inside the block; callers pre-extend narrow sources.

Decomposition:
- Shared package: the select-width helper function (clog2 with a minimum of 1) and named select constants for the CPU forwarding sources (e.g. SEL_REGFILE=0, SEL_EX_MEM=1, SEL_MEM_WB=2).
- One natural sub-module: sel_mux_n, a purely combinational N:1 select with out-of-range default, instantiated once by pipe_sel_reg.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0; pull reset_n low between clock edges -> out_valid, out_data, sel_err and err_count are 0 immediately, before the next edge.
- Basic select, WIDTH=32, N=4: channels {0x11,0x22,0x33,0x44}, in_sel=2, in_valid=1, out_ready=1 -> next cycle out_data=0x33, out_valid=1. Streaming sel=0,1,3 gives 0x11,0x22,0x44 on consecutive cycles with no bubbles.
- Stall: out_ready=0 for 3 cycles while in_valid=1 with sel changing -> in_ready=0; out_data stays 0x33. Raise out_ready -> the held beat is consumed and the new beat is registered in the same cycle.
- Flush: out_valid=1, out_ready=0; flush=1 with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0 and no new beat is registered.
- Out-of-range, N=3, DEFAULT_VAL=0xDEAD: accept in_sel=3 -> out_data=0xDEAD, sel_err=1, err_count=1. With CNT_W=2, five more bad accepts -> err_count saturates at 3.
- Clear collision: err_clr=1 in the same cycle as an accepted bad select -> sel_err=1, err_count=1. err_clr alone on the next cycle -> sel_err=0, err_count=0.

Source files
------------

// File: rtl/pipe_sel_reg_pkg.sv
// Shared select-width helper and forwarding-source select codes for operand latches.
// Select encodings are fixed so forwarding units and pipeline registers agree on them.
package pipe_sel_reg_pkg;

  localparam int SEL_REGFILE = 0;
  localparam int SEL_EX_MEM  = 1;
  localparam int SEL_MEM_WB  = 2;

  // A 2-way select still needs one select bit, so clamp below at 1.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_sel_reg_sel_mux_n.sv
// Combinational N:1 channel select, zero latency, no flow control.
// Codes at or above N return DEFAULT_VAL and raise sel_oor.
module sel_mux_n #(
  parameter int               WIDTH       = 32,
  parameter int               N           = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               sel_oor
);

  always_comb begin
    out_data = DEFAULT_VAL;
    sel_oor  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (32'(sel) == k) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_sel_reg.sv
// Registered N-way operand select with valid/ready: 1-cycle latency, full throughput.
// Holds the beat while stalled; flush kills it and blocks acceptance for that cycle.
module pipe_sel_reg
  import pipe_sel_reg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               N           = 4,
  parameter int               SEL_W       = sel_w(N),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic               sel_err,
  output logic [CNT_W-1:0]   err_count
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] mux_data;
  logic             mux_oor;
  logic             accept;

  sel_mux_n #(
    .WIDTH       (WIDTH),
    .N           (N),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (mux_data),
    .sel_oor  (mux_oor)
  );

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear is applied first so a coincident bad accept is still counted.
  always_comb begin
    sel_err_d   = sel_err_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      sel_err_d   = 1'b0;
      err_count_d = '0;
    end
    if (accept && mux_oor) begin
      sel_err_d = 1'b1;
      if (err_count_d != {CNT_W{1'b1}}) begin
        err_count_d = err_count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Directed bench: 4-way 32-bit instance for flow control, 3-way instance for range errors.
module tb_pipe_sel_reg;

  logic clk;
  logic reset_n;

  logic [127:0] in_data4;
  logic [1:0]   in_sel4;
  logic         in_valid4, in_ready4, flush4, out_valid4, out_ready4, err_clr4, sel_err4;
  logic [31:0]  out_data4;
  logic [7:0]   err_count4;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3, in_ready3, flush3, out_valid3, out_ready3, err_clr3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   err_count3;

  int n_asrt = 0;
  int n_fail = 0;

  pipe_sel_reg u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data4), .in_sel(in_sel4), .in_valid(in_valid4), .in_ready(in_ready4),
    .flush(flush4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .err_clr(err_clr4), .sel_err(sel_err4), .err_count(err_count4)
  );

  pipe_sel_reg #(.WIDTH(32), .N(3), .DEFAULT_VAL(32'hDEAD), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .flush(flush3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_clr(err_clr3), .sel_err(sel_err3), .err_count(err_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_data4 = {32'h44, 32'h33, 32'h22, 32'h11};
    in_sel4 = 2'd0; in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b1; err_clr4 = 1'b0;
    in_data3 = {32'h33, 32'h22, 32'h11};
    in_sel3 = 2'd0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1; err_clr3 = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_data", out_data4, 32'd0);
    chk("rst_err", {31'd0, sel_err4}, 32'd0);
    chk("rst_cnt", {24'd0, err_count4}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Basic select then streaming with no bubbles
    in_sel4 = 2'd2; in_valid4 = 1'b1;
    #1 chk("rdy_idle", {31'd0, in_ready4}, 32'd1);
    tick(); chk("sel2_data", out_data4, 32'h33); chk("sel2_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd0;
    tick(); chk("sel0_data", out_data4, 32'h11); chk("sel0_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd1;
    tick(); chk("sel1_data", out_data4, 32'h22); chk("sel1_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd3;
    tick(); chk("sel3_data", out_data4, 32'h44); chk("sel3_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd2;
    tick(); chk("sel2b_data", out_data4, 32'h33);

    // Stall for three cycles with select changing underneath
    out_ready4 = 1'b0; in_sel4 = 2'd0;
    #1 chk("stall_rdy", {31'd0, in_ready4}, 32'd0);
    tick(); chk("stall1_data", out_data4, 32'h33); chk("stall1_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd1;
    tick(); chk("stall2_data", out_data4, 32'h33);
    in_sel4 = 2'd3;
    tick(); chk("stall3_data", out_data4, 32'h33); chk("stall3_valid", {31'd0, out_valid4}, 32'd1);
    in_sel4 = 2'd1; out_ready4 = 1'b1;
    #1 chk("unstall_rdy", {31'd0, in_ready4}, 32'd1);
    tick(); chk("unstall_data", out_data4, 32'h22); chk("unstall_valid", {31'd0, out_valid4}, 32'd1);

    // Flush while stalled
    out_ready4 = 1'b0; flush4 = 1'b1; in_sel4 = 2'd3;
    #1 chk("flush_rdy", {31'd0, in_ready4}, 32'd0);
    tick(); chk("flush_valid", {31'd0, out_valid4}, 32'd0); chk("flush_data", out_data4, 32'h22);
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    tick(); chk("postflush_valid", {31'd0, out_valid4}, 32'd0);

    // Drain: valid drops, data holds
    in_valid4 = 1'b1; in_sel4 = 2'd0;
    tick(); chk("drain_in_data", out_data4, 32'h11);
    in_valid4 = 1'b0;
    tick(); chk("drain_valid", {31'd0, out_valid4}, 32'd0); chk("drain_data", out_data4, 32'h11);
    chk("n4_no_err", {31'd0, sel_err4}, 32'd0);

    // Out-of-range handling on the 3-way instance
    in_valid3 = 1'b1; in_sel3 = 2'd3;
    tick(); chk("oor_data", out_data3, 32'hDEAD); chk("oor_err", {31'd0, sel_err3}, 32'd1);
    chk("oor_cnt", {30'd0, err_count3}, 32'd1);
    in_sel3 = 2'd1;
    tick(); chk("ok3_data", out_data3, 32'h22); chk("ok3_cnt", {30'd0, err_count3}, 32'd1);
    in_valid3 = 1'b0; in_sel3 = 2'd3;
    tick(); chk("noacc_valid", {31'd0, out_valid3}, 32'd0); chk("noacc_cnt", {30'd0, err_count3}, 32'd1);
    in_valid3 = 1'b1;
    tick(); chk("bad2_cnt", {30'd0, err_count3}, 32'd2);
    tick(); chk("bad3_cnt", {30'd0, err_count3}, 32'd3);
    tick();
    tick();
    tick(); chk("sat_cnt", {30'd0, err_count3}, 32'd3); chk("sat_data", out_data3, 32'hDEAD);

    // Clear coinciding with a bad accept, then clear alone
    err_clr3 = 1'b1;
    tick(); chk("coll_err", {31'd0, sel_err3}, 32'd1); chk("coll_cnt", {30'd0, err_count3}, 32'd1);
    in_valid3 = 1'b0;
    tick(); chk("clr_err", {31'd0, sel_err3}, 32'd0); chk("clr_cnt", {30'd0, err_count3}, 32'd0);
    err_clr3 = 1'b0;

    // Asynchronous reset in the middle of a stall
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0; out_ready3 = 1'b0;
    in_valid4 = 1'b1; in_sel4 = 2'd3;
    tick();
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    tick(); chk("pre_rst_data", out_data4, 32'h44); chk("pre_rst_valid", {31'd0, out_valid4}, 32'd1);
    chk("pre_rst_cnt3", {30'd0, err_count3}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid4}, 32'd0);
    chk("arst_data", out_data4, 32'd0);
    chk("arst_valid3", {31'd0, out_valid3}, 32'd0);
    chk("arst_data3", out_data3, 32'd0);
    chk("arst_err3", {31'd0, sel_err3}, 32'd0);
    chk("arst_cnt3", {30'd0, err_count3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
